// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS), one transaction in flight,
// with a response watchdog. Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed LS priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

    state_t           state_q;
    owner_t           owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ls_wins_c;
    logic             timeout_c;

`ifdef MEM_ARB_RR_EN
    owner_t last_q;

    // On a tie the requester that was not granted last wins.
    always_comb ls_wins_c = ls_req & (~if_req | (last_q == OWN_IF));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_LS;
        end else if (if_gnt | ls_gnt) begin
            last_q <= ls_gnt ? OWN_LS : OWN_IF;
        end
    end
`else
    always_comb ls_wins_c = ls_req;
`endif

    always_comb timeout_c = (state_q == BUSY) & ~mem_rvalid & (cnt_q == CNT_W'(TIMEOUT - 1));

    // Request routing, grants and response steering; everything is held at 0 while in reset.
    always_comb begin
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        err       = 1'b0;
        if (rst && state_q == IDLE) begin
            mem_req = if_req | ls_req;
            if (ls_wins_c) begin
                mem_we    = ls_we;
                mem_addr  = ls_addr;
                mem_wdata = ls_wdata;
                mem_wstrb = ls_wstrb;
                ls_gnt    = mem_gnt;
            end else if (if_req) begin
                mem_addr = if_addr;
                if_gnt   = mem_gnt;
            end
        end else if (rst && state_q == BUSY) begin
            if (mem_rvalid) begin
                if (owner_q == OWN_LS) begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = mem_rdata;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
            end else if (timeout_c) begin
                err = 1'b1;
                if (owner_q == OWN_LS) ls_rvalid = 1'b1;
                else                   if_rvalid = 1'b1;
            end
        end
    end

    // Transaction state, owner and watchdog counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_gnt | ls_gnt) begin
                        owner_q <= ls_gnt ? OWN_LS : OWN_IF;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_rvalid | timeout_c) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
